// File: rtl/alu_reg.sv
// rtl/alu_reg.sv - 32-bit RV32I-style ALU with registered result and flags

typedef logic [3:0] alu_control_t;

module alu_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

  localparam int SHW = 5;

  localparam alu_control_t OP_AND  = 4'b0001;
  localparam alu_control_t OP_OR   = 4'b0010;
  localparam alu_control_t OP_XOR  = 4'b0011;
  localparam alu_control_t OP_SLL  = 4'b0101;
  localparam alu_control_t OP_SRL  = 4'b0110;
  localparam alu_control_t OP_SRA  = 4'b0111;
  localparam alu_control_t OP_ADD  = 4'b1000;
  localparam alu_control_t OP_SUB  = 4'b1100;
  localparam alu_control_t OP_SLT  = 4'b1101;
  localparam alu_control_t OP_SLTU = 4'b1111;

  // Operation decode
  logic sub_mode;
  logic is_add;
  logic is_sub;
  logic shift_left;
  logic shift_arith;

  // Decode which datapath units are steered by the current control code
  always_comb begin
    is_add      = (control == OP_ADD);
    is_sub      = (control == OP_SUB);
    sub_mode    = (control == OP_SUB) || (control == OP_SLT) || (control == OP_SLTU);
    shift_left  = (control == OP_SLL);
    shift_arith = (control == OP_SRA);
  end

  // Adder/subtractor: ripple carry over generate/propagate terms.
  // Subtraction is a + ~b + 1, so the carry-in is the sub_mode bit.
  logic [N-1:0] b_eff;
  logic [N-1:0] gen_bit;
  logic [N-1:0] prop_bit;
  logic [N:0]   carry;
  logic [N-1:0] sum;

  assign b_eff    = b ^ {N{sub_mode}};
  assign gen_bit  = a & b_eff;
  assign prop_bit = a ^ b_eff;
  assign carry[0] = sub_mode;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_adder
      assign sum[gi]     = prop_bit[gi] ^ carry[gi];
      assign carry[gi+1] = gen_bit[gi] | (prop_bit[gi] & carry[gi]);
    end
  endgenerate

  // Signed overflow of the add/sub path: operands of equal sign (after the
  // b inversion for subtract) producing a result of the other sign.
  logic arith_ovf;
  assign arith_ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

  // Comparator built on the subtractor. Signed less-than corrects the sign
  // bit by the overflow flag so it stays right when a - b wraps; unsigned
  // less-than is a borrow, i.e. no carry out of a + ~b + 1.
  logic less_signed;
  logic less_unsigned;
  assign less_signed   = sum[N-1] ^ arith_ovf;
  assign less_unsigned = ~carry[N];

  // Equality is a pure XOR reduction, independent of control.
  logic equal_d;
  assign equal_d = ~|(a ^ b);

  // Barrel shifter: one right-shifting log stage per amount bit. Left shifts
  // reuse it by bit-reversing the operand on the way in and out.
  logic [SHW-1:0] sh_amt;
  logic           fill_bit;
  logic [N-1:0]   sh_in;
  logic [N-1:0]   sh_out;
  logic [N-1:0]   stage [0:SHW];

  assign sh_amt   = b[SHW-1:0];
  assign fill_bit = shift_arith & a[N-1];

  // Present the operand to the right shifter, reversed for left shifts
  always_comb begin
    sh_in = '0;
    for (int i = 0; i < N; i++) begin
      sh_in[i] = shift_left ? a[N-1-i] : a[i];
    end
  end

  assign stage[0] = sh_in;

  genvar gk;
  generate
    for (gk = 0; gk < SHW; gk++) begin : g_shift
      localparam int S = 1 << gk;
      assign stage[gk+1] = sh_amt[gk] ? {{S{fill_bit}}, stage[gk][N-1:S]} : stage[gk];
    end
  endgenerate

  // Undo the input reversal so left shifts come out in natural bit order
  always_comb begin
    sh_out = '0;
    for (int i = 0; i < N; i++) begin
      sh_out[i] = shift_left ? stage[SHW][N-1-i] : stage[SHW][i];
    end
  end

  // Next-state result and overflow selection
  logic [N-1:0] result_d;
  logic         overflow_d;

  // Select the unit output for the current op; undefined codes give zero
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (control)
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_SLL,
      OP_SRL,
      OP_SRA:  result_d = sh_out;
      OP_ADD:  result_d = sum;
      OP_SUB:  result_d = sum;
      OP_SLT:  result_d = {{(N-1){1'b0}}, less_signed};
      OP_SLTU: result_d = {{(N-1){1'b0}}, less_unsigned};
      default: result_d = '0;
    endcase
    overflow_d = (is_add || is_sub) && arith_ovf;
  end

  // Output registers: capture every edge, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      equal    <= 1'b0;
    end else begin
      result   <= result_d;
      overflow <= overflow_d;
      zero     <= ~|result_d;
      equal    <= equal_d;
    end
  end

endmodule

// File: tb/tb_alu_reg.sv
// tb/tb_alu_reg.sv - randomized and directed checks of alu_reg against a behavioural model

module tb_alu_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        equal;

  int n_tests;
  int n_fail;

  alu_reg #(.N(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .control  (control),
    .result   (result),
    .overflow (overflow),
    .zero     (zero),
    .equal    (equal)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: arithmetic straight from the operation definitions
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ov);
    longint s;
    r  = 32'h0;
    ov = 1'b0;
    case (c)
      4'b0001: r = x & y;
      4'b0010: r = x | y;
      4'b0011: r = x ^ y;
      4'b0101: r = x << y[4:0];
      4'b0110: r = x >> y[4:0];
      4'b0111: r = $signed(x) >>> y[4:0];
      4'b1000: begin
        r  = x + y;
        s  = longint'($signed(x)) + longint'($signed(y));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1100: begin
        r  = x - y;
        s  = longint'($signed(x)) - longint'($signed(y));
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1111: r = (x < y) ? 32'd1 : 32'd0;
      default: begin
        r  = 32'h0;
        ov = 1'b0;
      end
    endcase
  endfunction

  // Apply one operation, wait one edge, compare all four outputs with the model
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] er;
    logic        eov;
    model(c, x, y, er, eov);
    control = c;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
    check({tag, "_res"}, result, er);
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, eov});
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (er == 32'h0)});
    check({tag, "_eq"}, {31'b0, equal}, {31'b0, (x == y)});
  endtask

  logic [3:0]  ops [14];
  logic [31:0] corners [9];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    a       = 32'h0;
    b       = 32'h0;
    control = 4'h0;

    ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
            4'b1100, 4'b1101, 4'b1111, 4'b0000, 4'b0100, 4'b1001, 4'b1110};
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                32'h55555555, 32'hAAAAAAAA, 32'h0000001F, 32'h00000020};

    // Reset state
    #12;
    check("rst_res", result, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_eq", {31'b0, equal}, 32'h0);
    #1 rst_n = 1'b1;

    run_op(4'b1000, 32'd1, 32'd2, "add_first");
    check("add_first_const", result, 32'd3);

    // Add overflow and wrap to zero
    run_op(4'b1000, 32'h7FFFFFFF, 32'h1, "add_ovf");
    check("add_ovf_const", {result[31:0]}, 32'h80000000);
    check("add_ovf_flag", {31'b0, overflow}, 32'h1);
    run_op(4'b1000, 32'hFFFFFFFF, 32'h1, "add_wrap");
    check("add_wrap_zero", {31'b0, zero}, 32'h1);
    check("add_wrap_ovf", {31'b0, overflow}, 32'h0);

    // Subtract overflow and equality
    run_op(4'b1100, 32'h80000000, 32'h1, "sub_ovf");
    check("sub_ovf_const", result, 32'h7FFFFFFF);
    check("sub_ovf_flag", {31'b0, overflow}, 32'h1);
    run_op(4'b1100, 32'h12345678, 32'h12345678, "sub_eq");
    check("sub_eq_zero", {31'b0, zero}, 32'h1);
    check("sub_eq_equal", {31'b0, equal}, 32'h1);

    // Shifts ignore b[31:5]
    run_op(4'b0101, 32'h80000001, 32'h21, "sll");
    check("sll_const", result, 32'h00000002);
    run_op(4'b0110, 32'h80000001, 32'h21, "srl");
    check("srl_const", result, 32'h40000000);
    run_op(4'b0111, 32'h80000001, 32'h21, "sra");
    check("sra_const", result, 32'hC0000000);

    // Compares
    run_op(4'b1101, 32'hFFFFFFFF, 32'h1, "slt_neg");
    check("slt_neg_const", result, 32'h1);
    run_op(4'b1111, 32'hFFFFFFFF, 32'h1, "sltu_big");
    check("sltu_big_const", result, 32'h0);
    run_op(4'b1101, 32'h80000000, 32'h7FFFFFFF, "slt_wrap");
    check("slt_wrap_const", result, 32'h1);

    // Asynchronous reset mid-cycle with a nonzero result held
    run_op(4'b1000, 32'd5, 32'd6, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res", result, 32'h0);
    check("async_rst_ovf", {31'b0, overflow}, 32'h0);
    check("async_rst_zero", {31'b0, zero}, 32'h0);
    check("async_rst_eq", {31'b0, equal}, 32'h0);
    #2 rst_n = 1'b1;
    run_op(4'b1000, 32'd1, 32'd2, "post_rst");
    check("post_rst_const", result, 32'd3);

    // Corner sweep and random pairs for every op, including undefined codes
    foreach (ops[oi]) begin
      foreach (corners[xi]) begin
        foreach (corners[yi]) begin
          run_op(ops[oi], corners[xi], corners[yi], $sformatf("sw%0h", ops[oi]));
        end
      end
      for (int r = 0; r < 25; r++) begin
        run_op(ops[oi], $urandom, $urandom, $sformatf("rnd%0h", ops[oi]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit RV32I-style integer ALU with registered outputs. Used as the execute-stage datapath block of the course CPU.
- Each rising clock edge registers `result` and three flags (`overflow`, `zero`, `equal`). They are computed from the current `a`, `b` and `control`.
- A combinational `alu_behavioural`-equivalent golden model, registered identically, is the verification reference.

Parameters:
- N, 32, datapath width. Only 32 must be supported. The shift amount width is fixed at 5 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  N  operand A.
- b  input  N  operand B. Bits [4:0] are the shift amount for shift operations.
- control  input  4  operation select, of type alu_control_t.
- result  output  N  registered operation result.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered flag, high when the result is all zeros.
- equal  output  1  registered flag, high when a == b.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: while rst_n = 0, result = 0, overflow = 0, zero = 0 and equal = 0, regardless of clk.
  - rst_n deassertion is taken synchronously.
  - The first capture is at the first rising clk edge after deassertion.
  - Reset asserted mid-operation clears all outputs immediately.
- Latency: one cycle. Inputs sampled at edge k appear on the outputs after edge k. One new operation is accepted per cycle, with no handshake. Outputs hold between edges.
- Control encoding (4 bits):
  - AND = 0001, OR = 0010, XOR = 0011.
  - SLL = 0101, SRL = 0110, SRA = 0111.
  - ADD = 1000, SUB = 1100, SLT = 1101, SLTU = 1111.
  - All other codes: result = 0, overflow = 0. zero and equal are still computed normally.
- Logic ops: bitwise on a and b.
- Shifts: shift amount is b[4:0]; b[31:5] is ignored.
  - SLL shifts left and fills with 0.
  - SRL shifts right logically.
  - SRA shifts right and replicates a[31].
- ADD: result = (a + b) mod 2^32.
- SUB: result = (a - b) mod 2^32.
- Overflow flag:
  - ADD: overflow = 1 iff a[31] == b[31] and result[31] != a[31].
  - SUB: overflow = 1 iff a[31] != b[31] and result[31] != a[31].
  - All other ops: overflow = 0.
  - Unsigned carry/borrow is not reported.
- SLT: result = 1 if signed a < signed b, else 0. The comparison must be correct even when a - b overflows.
- SLTU: result = 1 if unsigned a < unsigned b, else 0.
- zero: 1 iff the registered result is 0, for every op, including undefined codes.
- equal: 1 iff a == b, independent of control.
- Outputs must never be X/Z after reset is released, given known inputs.
- Target implementation: structural adder/subtractor, shifter and comparator. Roughly 120-400 lines.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with result nonzero. Required: all outputs go to 0 immediately, with no clk edge. Release rst_n, apply ADD a=1 b=2. Required: result=3 after the next edge.
- ADD overflow: a=7FFFFFFF, b=00000001. Required: result=80000000, overflow=1, zero=0. Then a=FFFFFFFF, b=00000001. Required: result=0, overflow=0, zero=1.
- SUB and equal: a=80000000, b=00000001. Required: result=7FFFFFFF, overflow=1. Then a=b=12345678. Required: result=0, zero=1, equal=1.
- Shifts: a=80000001 with b=00000021. Required: shift amount is 1.
  - SLL gives 00000002.
  - SRL gives 40000000.
  - SRA gives C0000000.
- Compares: a=FFFFFFFF, b=00000001.
  - SLT gives 1; SLTU gives 0.
  - a=80000000, b=7FFFFFFF with SLT gives 1 (the subtraction overflows).
- Sweep: every op against the corner set {0, 1, FFFFFFFF, 7FFFFFFF, 80000000, 55555555, AAAAAAAA, 0000001F, 00000020} crossed, plus 25 random pairs per op. Required: outputs match the registered golden model exactly, one cycle later.
